// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-lockable write arbiter in front of a shared FIFO,
// plus a registered valid/ready stage draining the FIFO head.
module fifo_wr_arbiter #(
   parameter int WIDTH    = 32,
   parameter int NREQ     = 4,
   parameter int DEPTH    = 16,
   parameter int LOCK_MAX = 8,
   parameter int IDW      = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         lock,
   input  logic [NREQ*WIDTH-1:0]   data,
   output logic [NREQ-1:0]         gnt,
   output logic                    fifo_enq,
   output logic [IDW+WIDTH-1:0]    fifo_din,
   input  logic                    fifo_full,
   output logic                    fifo_deq,
   input  logic [IDW+WIDTH-1:0]    fifo_dout,
   input  logic                    fifo_empty,
   output logic                    m_valid,
   output logic [WIDTH-1:0]        m_data,
   output logic [IDW-1:0]          m_src,
   input  logic                    m_ready,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    locked
);

   localparam int CW = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);
   localparam int LW = $clog2(DEPTH) + 1;

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   rr_q, rr_d;
   logic [IDW-1:0]   owner_q, owner_d;
   logic [CW-1:0]    beat_q, beat_d;
   logic [LW-1:0]    level_q, level_d;
   logic             m_valid_q, m_valid_d;
   logic [WIDTH-1:0] m_data_q, m_data_d;
   logic [IDW-1:0]   m_src_q, m_src_d;

   logic             load;
   logic             room;
   logic             found;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   idx;
   logic [IDW-1:0]   sel;

   function automatic logic [IDW-1:0] inc(input logic [IDW-1:0] i);
      if (32'(i) == NREQ - 1) return '0;
      return i + 1'b1;
   endfunction

   // Drain decision depends only on FIFO/output state, never on req.
   always_comb begin
      load      = !rst && !fifo_empty && (!m_valid_q || m_ready);
      room      = !fifo_full || load;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_src_d   = m_src_q;
      if (load) begin
         m_valid_d = 1'b1;
         m_data_d  = fifo_dout[WIDTH-1:0];
         m_src_d   = fifo_dout[IDW+WIDTH-1:WIDTH];
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = rr_q;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
         idx = inc(idx);
      end
   end

   always_comb begin
      gnt      = '0;
      fifo_enq = 1'b0;
      state_d  = state_q;
      rr_d     = rr_q;
      owner_d  = owner_q;
      beat_d   = beat_q;
      sel      = (state_q == LOCKED) ? owner_q : win;
      fifo_din = {sel, data[32'(sel)*WIDTH +: WIDTH]};
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               if (found && room) begin
                  gnt[win] = 1'b1;
                  fifo_enq = 1'b1;
                  rr_d     = inc(win);
                  if (lock[win] && LOCK_MAX != 1) begin
                     state_d = LOCKED;
                     owner_d = win;
                     beat_d  = CW'(1);
                  end
               end
            end
            LOCKED: begin
               if (!req[owner_q]) begin
                  state_d = IDLE;
                  rr_d    = inc(owner_q);
               end else if (room) begin
                  gnt[owner_q] = 1'b1;
                  fifo_enq     = 1'b1;
                  beat_d       = beat_q + 1'b1;
                  if (!lock[owner_q] ||
                      (LOCK_MAX != 0 && beat_d == LMAX)) begin
                     state_d = IDLE;
                     rr_d    = inc(owner_q);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      level_d = level_q;
      unique case ({fifo_enq, load})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rr_q      <= '0;
         owner_q   <= '0;
         beat_q    <= '0;
         level_q   <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_src_q   <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         owner_q   <= owner_d;
         beat_q    <= beat_d;
         level_q   <= level_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_src_q   <= m_src_d;
      end
   end

   assign fifo_deq = load;
   assign m_valid  = m_valid_q;
   assign m_data   = m_data_q;
   assign m_src    = m_src_q;
   assign level    = level_q;
   assign locked   = (state_q == LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: FIFO environment model, directed vector
// table, corner sequences and a randomized run against a reference model.
module tb_fifo_wr_arbiter;

   localparam int WIDTH    = 32;
   localparam int NREQ     = 4;
   localparam int DEPTH    = 16;
   localparam int LOCK_MAX = 8;
   localparam int IDW      = $clog2(NREQ);
   localparam int LW       = $clog2(DEPTH) + 1;
   localparam int PW       = $clog2(DEPTH);

   logic                   clk;
   logic                   rst;
   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        lock;
   logic [NREQ*WIDTH-1:0]  data;
   logic [NREQ-1:0]        gnt;
   logic                   fifo_enq;
   logic [IDW+WIDTH-1:0]   fifo_din;
   logic                   fifo_full;
   logic                   fifo_deq;
   logic [IDW+WIDTH-1:0]   fifo_dout;
   logic                   fifo_empty;
   logic                   m_valid;
   logic [WIDTH-1:0]       m_data;
   logic [IDW-1:0]         m_src;
   logic                   m_ready;
   logic [LW-1:0]          level;
   logic                   locked;

   fifo_wr_arbiter #(
      .WIDTH(WIDTH), .NREQ(NREQ), .DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .data(data),
      .gnt(gnt), .fifo_enq(fifo_enq), .fifo_din(fifo_din),
      .fifo_full(fifo_full), .fifo_deq(fifo_deq), .fifo_dout(fifo_dout),
      .fifo_empty(fifo_empty), .m_valid(m_valid), .m_data(m_data),
      .m_src(m_src), .m_ready(m_ready), .level(level), .locked(locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External FIFO: capacity DEPTH-1, combinational head.
   logic [IDW+WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]        rd_p, wr_p;
   int                   cnt;

   always @(posedge clk) begin
      if (rst) begin
         rd_p <= '0;
         wr_p <= '0;
         cnt  <= 0;
      end else begin
         if (fifo_deq) rd_p <= rd_p + 1'b1;
         if (fifo_enq) begin
            mem[wr_p] <= fifo_din;
            wr_p      <= wr_p + 1'b1;
         end
         cnt <= cnt + (fifo_enq ? 1 : 0) - (fifo_deq ? 1 : 0);
      end
   end

   assign fifo_empty = (cnt == 0);
   assign fifo_full  = (cnt == DEPTH - 1);
   assign fifo_dout  = mem[rd_p];

   // Reference model
   typedef struct {
      logic [IDW-1:0]   src;
      logic [WIDTH-1:0] pl;
   } ent_t;

   ent_t mq[$];
   bit   m_ov;
   ent_t m_out;
   int   m_rr;
   int   m_owner;
   int   m_beats;

   int n_cmp;
   int n_bad;

   task automatic cmp(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ov    = 1'b0;
      m_rr    = 0;
      m_owner = -1;
      m_beats = 0;
   endtask

   task automatic model_check();
      int   sz;
      bit   e_deq;
      bit   e_room;
      int   w;
      int   i;
      ent_t e;
      sz     = mq.size();
      e_deq  = !rst && sz > 0 && (!m_ov || m_ready);
      e_room = (sz < DEPTH - 1) || e_deq;
      w      = -1;
      if (!rst && e_room) begin
         if (m_owner >= 0) begin
            if (req[m_owner]) w = m_owner;
         end else begin
            for (int k = 0; k < NREQ; k++) begin
               i = (m_rr + k) % NREQ;
               if (w < 0 && req[i]) w = i;
            end
         end
      end
      cmp("gnt", 64'(gnt), (w >= 0) ? 64'(1) << w : 64'(0));
      cmp("fifo_enq", 64'(fifo_enq), 64'(w >= 0));
      cmp("fifo_deq", 64'(fifo_deq), 64'(e_deq));
      cmp("level", 64'(level), 64'(sz));
      cmp("m_valid", 64'(m_valid), 64'(m_ov));
      cmp("locked", 64'(locked), 64'(m_owner >= 0));
      if (m_ov) begin
         cmp("m_data", 64'(m_data), 64'(m_out.pl));
         cmp("m_src", 64'(m_src), 64'(m_out.src));
      end
      if (w >= 0) begin
         cmp("fifo_din", 64'(fifo_din),
             {30'd0, w[IDW-1:0], data[w*WIDTH +: WIDTH]});
      end
      if (rst) begin
         model_reset();
      end else begin
         if (e_deq) begin
            m_out = mq.pop_front();
            m_ov  = 1'b1;
         end else if (m_ready) begin
            m_ov = 1'b0;
         end
         if (w >= 0) begin
            e.src = w[IDW-1:0];
            e.pl  = data[w*WIDTH +: WIDTH];
            mq.push_back(e);
         end
         if (m_owner >= 0) begin
            if (!req[m_owner]) begin
               m_rr    = (m_owner + 1) % NREQ;
               m_owner = -1;
            end else if (w >= 0) begin
               m_beats++;
               if (!lock[m_owner] || (LOCK_MAX != 0 && m_beats == LOCK_MAX)) begin
                  m_rr    = (m_owner + 1) % NREQ;
                  m_owner = -1;
               end
            end
         end else if (w >= 0) begin
            m_rr = (w + 1) % NREQ;
            if (lock[w] && LOCK_MAX != 1) begin
               m_owner = w;
               m_beats = 1;
            end
         end
      end
   endtask

   task automatic apply(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                        input logic rd, input logic rs, input bit rnd);
      req     = r;
      lock    = l;
      m_ready = rd;
      rst     = rs;
      for (int k = 0; k < NREQ; k++) begin
         data[k*WIDTH +: WIDTH] = rnd ? WIDTH'($urandom) : WIDTH'(32'h100 + k);
      end
      #4;
      model_check();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic            rst;
      logic [NREQ-1:0] req;
      logic [NREQ-1:0] lock;
      logic            rdy;
      logic [NREQ-1:0] gnt;
      logic            lkd;
      logic            chk_m;
      logic            mv;
      logic [IDW-1:0]  src;
      logic [LW-1:0]   lvl;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rs, input logic [3:0] r,
                               input logic [3:0] l, input logic rd,
                               input logic [3:0] g, input logic lk,
                               input logic cm, input logic mv,
                               input logic [1:0] s, input logic [4:0] lv);
      vec_t v;
      v.rst = rs; v.req = r; v.lock = l; v.rdy = rd; v.gnt = g;
      v.lkd = lk; v.chk_m = cm; v.mv = mv; v.src = s; v.lvl = lv;
      return v;
   endfunction

   int ngr;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      req = '0; lock = '0; data = '0; m_ready = 1'b0; rst = 1'b1;
      model_reset();
      tick();
      tick();

      // Round-robin with free-flowing drain
      vecs.push_back(mk(0, 4'hF, 4'h0, 1, 4'h1, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'h0, 1, 4'h2, 0, 1, 0, 0, 1));
      vecs.push_back(mk(0, 4'hF, 4'h0, 1, 4'h4, 0, 1, 1, 0, 1));
      vecs.push_back(mk(0, 4'hF, 4'h0, 1, 4'h8, 0, 1, 1, 1, 1));
      vecs.push_back(mk(0, 4'hF, 4'h0, 1, 4'h1, 0, 1, 1, 2, 1));
      vecs.push_back(mk(0, 4'hF, 4'h0, 1, 4'h2, 0, 1, 1, 3, 1));
      vecs.push_back(mk(1, 4'hF, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0));
      // Locked burst capped at LOCK_MAX, then owner drop
      vecs.push_back(mk(0, 4'h2, 4'h2, 1, 4'h2, 0, 0, 0, 0, 0));
      for (int k = 0; k < 7; k++)
         vecs.push_back(mk(0, 4'hB, 4'h2, 1, 4'h2, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'hB, 4'h2, 1, 4'h8, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'hB, 4'h2, 1, 4'h1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'hB, 4'h2, 1, 4'h2, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'h9, 4'h2, 1, 4'h0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'h9, 4'h2, 1, 4'h8, 0, 0, 0, 0, 0));

      foreach (vecs[n]) begin
         apply(vecs[n].req, vecs[n].lock, vecs[n].rdy, vecs[n].rst, 0);
         cmp($sformatf("vec%0d_gnt", n), 64'(gnt), 64'(vecs[n].gnt));
         cmp($sformatf("vec%0d_locked", n), 64'(locked), 64'(vecs[n].lkd));
         if (vecs[n].chk_m) begin
            cmp($sformatf("vec%0d_mvalid", n), 64'(m_valid), 64'(vecs[n].mv));
            cmp($sformatf("vec%0d_level", n), 64'(level), 64'(vecs[n].lvl));
            if (vecs[n].mv) begin
               cmp($sformatf("vec%0d_msrc", n), 64'(m_src), 64'(vecs[n].src));
               cmp($sformatf("vec%0d_mdata", n), 64'(m_data),
                   64'(32'h100 + vecs[n].src));
            end
         end
         tick();
      end

      // Fill to capacity with a stalled consumer
      apply(4'h0, 4'h0, 0, 1, 0);
      tick();
      ngr = 0;
      for (int k = 0; k < 20; k++) begin
         apply(4'h4, 4'h0, 0, 0, 0);
         if (gnt[2]) ngr++;
         if (k == 19) cmp("full_gnt_zero", 64'(gnt), 64'(0));
         tick();
      end
      cmp("full_grants", 64'(ngr), 64'(16));
      for (int k = 0; k < 5; k++) begin
         apply(4'h4, 4'h0, 1, 0, 0);
         cmp("full_pass_gnt", 64'(gnt), 64'(4));
         cmp("full_pass_deq", 64'(fifo_deq), 64'(1));
         cmp("full_pass_level", 64'(level), 64'(15));
         tick();
      end

      // Consumer toggling ready 1010
      for (int k = 0; k < 24; k++) begin
         apply(4'hF, 4'h0, (k % 2) == 0, 0, 1);
         tick();
      end

      // Reset in the middle of a locked burst
      apply(4'h0, 4'h0, 1, 1, 0);
      tick();
      for (int k = 0; k < 6; k++) begin
         apply(4'h2, 4'h2, 0, 0, 0);
         tick();
      end
      apply(4'h2, 4'h2, 0, 1, 0);
      cmp("midburst_level", 64'(level), 64'(5));
      cmp("midburst_locked", 64'(locked), 64'(1));
      tick();
      apply(4'hF, 4'h0, 1, 0, 0);
      cmp("post_rst_mvalid", 64'(m_valid), 64'(0));
      cmp("post_rst_level", 64'(level), 64'(0));
      cmp("post_rst_locked", 64'(locked), 64'(0));
      cmp("post_rst_gnt", 64'(gnt), 64'(1));
      cmp("post_rst_mdata", 64'(m_data), 64'(0));
      cmp("post_rst_msrc", 64'(m_src), 64'(0));
      tick();

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         apply(NREQ'($urandom), NREQ'($urandom & $urandom),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 249) == 0), 1);
         tick();
      end
      for (int k = 0; k < 24; k++) begin
         apply(4'h0, 4'h0, 1, 0, 1);
         tick();
      end
      cmp("drained_model", 64'(mq.size()), 64'(0));
      cmp("drained_level", 64'(level), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares one myfifo instance between NREQ producers.
- Round-robin arbitration with optional burst lock drives the FIFO enqueue side; each entry is tagged with its source index.
- Drains the FIFO into a registered valid/ready output stage.
- Sits between peripheral producers (UART/DMA/debug) and a single consumer. Also exports FIFO level and an arbitration-busy flag.

Parameters:
- WIDTH, 32, payload bits per entry
- NREQ, 4, number of requesters (2..8)
- DEPTH, 16, depth of the attached FIFO (power of 2); usable capacity is DEPTH-1
- LOCK_MAX, 8, maximum consecutive beats for one locked owner; 0 = unlimited
- IDW, $clog2(NREQ), source tag width (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  NREQ  per-requester data valid
- lock  in  NREQ  per-requester request to keep the grant after the current beat
- data  in  NREQ*WIDTH  packed payloads; requester i uses data[i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot, combinational; beat of requester i is accepted this cycle
- fifo_enq  out  1  to FIFO enq
- fifo_din  out  IDW+WIDTH  to FIFO din: {src_id, payload}
- fifo_full  in  1  from FIFO full
- fifo_deq  out  1  to FIFO deq
- fifo_dout  in  IDW+WIDTH  from FIFO dout (combinational head)
- fifo_empty  in  1  from FIFO empty
- m_valid  out  1  output stage holds an entry
- m_data  out  WIDTH  output payload
- m_src  out  IDW  output source tag
- m_ready  in  1  consumer accepts m_data when m_valid & m_ready
- level  out  $clog2(DEPTH)+1  entries currently in FIFO (excludes output stage)
- locked  out  1  arbiter is in LOCKED state

Behaviour:
- Reset (rst=1 at posedge): rr_ptr=0, state=IDLE, owner=0, beat_cnt=0, m_valid=0, m_data=0, m_src=0, level=0. Combinational outputs during reset: gnt=0, fifo_enq=0, fifo_deq=0.
- Drain side:
  - load = !fifo_empty & (!m_valid | m_ready); fifo_deq = load.
  - On load: m_data/m_src <= fifo_dout fields and m_valid <= 1.
  - Else if m_ready: m_valid <= 0.
  - FIFO-to-m_valid latency is 1 cycle. Back-to-back loads sustain 1 entry/cycle.
  - m_data/m_src must hold stable while m_valid & !m_ready.
- Space: room = !fifo_full | fifo_deq. A full FIFO accepts when it dequeues the same cycle. No combinational path from req/gnt to fifo_deq.
- IDLE arbitration:
  - Search indices rr_ptr, rr_ptr+1, ... mod NREQ; the first with req=1 wins, provided room.
  - gnt[w]=1; fifo_enq=1; fifo_din={w, data[w]}.
  - Next cycle rr_ptr <= (w+1) mod NREQ.
  - If lock[w]=1 and LOCK_MAX!=1: state <= LOCKED, owner <= w, beat_cnt <= 1.
- LOCKED:
  - Only owner can be granted; other requesters get gnt=0 even with room.
  - Owner beat (req[owner] & room): beat_cnt++.
  - Exit to IDLE after the beat when lock[owner]=0, or when beat_cnt+1==LOCK_MAX (LOCK_MAX!=0).
  - Exit with no beat when req[owner]=0. A cycle with req[owner]=1 but no room holds the lock.
  - rr_ptr <= owner+1 on exit.
- No room: gnt=0, fifo_enq=0, rr_ptr and state unchanged.
- gnt is never asserted for i with req[i]=0. At most one gnt bit is set.
- level: +1 on enq only, -1 on deq only, unchanged on both or neither. Range 0..DEPTH-1.
- Reset mid-burst or mid-drain discards the output stage and lock state. The FIFO is reset by the same rst.

Test Plan:
- All 4 req=1, lock=0, continuous m_ready=1, data[i]=0x100+i -> gnt order 0,1,2,3,0,...; m_src sequence 0,1,2,3; first m_valid 2 cycles after first gnt.
- m_ready=0, req[2]=1 for 20 cycles -> exactly 15 grants (level reaches 15) plus 1 in output stage after the first load; then gnt=0. Raise m_ready -> grants resume in the same cycle as each deq; level holds 15.
- req[1] with lock=1, req[0,3]=1, LOCK_MAX=8 -> 8 consecutive gnt[1], locked=1 during the burst, then gnt[2] skipped (no req) and gnt[3] next.
- In LOCKED, owner drops req for one cycle -> locked=0 next cycle; round-robin resumes from owner+1.
- m_valid=1 with m_ready toggling 1010 -> m_data changes only after cycles with m_ready=1; no entry lost or duplicated (scoreboard by src/payload).
- Assert rst during a locked burst with level=5 -> next cycle m_valid=0, level=0, locked=0, gnt follows rr_ptr=0.
